// File: rtl/block_palette_unit_pkg.sv
// -----------------------------------------------------------------------------
// block_palette_unit_pkg
// Shared definitions for the block palette unit:
//   - block colour codes (PINK..ROSE) and their encoding width
//   - the default RGB value of every colour code (12-bit, 4 bits per channel)
//   - the default-palette table loaded into the palette on reset
// -----------------------------------------------------------------------------
package block_palette_unit_pkg;

    localparam int COLOR_ENCODE_LENGTH = 3;
    localparam int RGB_LENGTH          = 12;

    typedef enum logic [COLOR_ENCODE_LENGTH-1:0] {
        PINK   = 3'd0,
        YELLOW = 3'd1,
        ORANGE = 3'd2,
        CYAN   = 3'd3,
        RED    = 3'd4,
        BLUE   = 3'd5,
        VIOLET = 3'd6,
        ROSE   = 3'd7
    } color_code_e;

    localparam logic [RGB_LENGTH-1:0] PINK_RGB   = 12'hF9C;
    localparam logic [RGB_LENGTH-1:0] YELLOW_RGB = 12'hFF0;
    localparam logic [RGB_LENGTH-1:0] ORANGE_RGB = 12'hF80;
    localparam logic [RGB_LENGTH-1:0] CYAN_RGB   = 12'h0FF;
    localparam logic [RGB_LENGTH-1:0] RED_RGB    = 12'hF00;
    localparam logic [RGB_LENGTH-1:0] BLUE_RGB   = 12'h00F;
    localparam logic [RGB_LENGTH-1:0] VIOLET_RGB = 12'h80F;
    localparam logic [RGB_LENGTH-1:0] ROSE_RGB   = 12'hF08;

    // Reset image of the palette, in colour-code order.
    localparam logic [RGB_LENGTH-1:0] DEFAULT_PALETTE [0:7] = '{
        PINK_RGB, YELLOW_RGB, ORANGE_RGB, CYAN_RGB,
        RED_RGB,  BLUE_RGB,   VIOLET_RGB, ROSE_RGB
    };

    // Default value of palette entry idx; entries past the named colours are ROSE.
    function automatic logic [RGB_LENGTH-1:0] default_rgb(input int unsigned idx);
        logic [2:0] code;
        code = idx[2:0];
        if (idx < 32'd8)
            return DEFAULT_PALETTE[code];
        else
            return ROSE_RGB;
    endfunction

endpackage

// File: rtl/block_palette_unit_if.sv
// -----------------------------------------------------------------------------
// block_palette_unit_if
// Palette write port, lookup request and RGB result of the block palette unit.
//   WR_EN/WR_ADDR/WR_DATA   palette write strobe, entry, value
//   IN_VALID/COLOR          lookup request and colour index
//   BLINK/DIM               per-pixel effect selects
//   OUT_VALID/RGB           lookup result
//   BLINK_PHASE             current blink phase (1 = blanked half)
// master: pixel-fetch side (drives requests); slave: the palette unit.
// -----------------------------------------------------------------------------
interface block_palette_unit_if #(
    parameter int COLOR_W = 3,
    parameter int RGB_W   = 12
);
    logic               WR_EN;
    logic [COLOR_W-1:0] WR_ADDR;
    logic [RGB_W-1:0]   WR_DATA;
    logic               IN_VALID;
    logic [COLOR_W-1:0] COLOR;
    logic               BLINK;
    logic               DIM;
    logic               OUT_VALID;
    logic [RGB_W-1:0]   RGB;
    logic               BLINK_PHASE;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, IN_VALID, COLOR, BLINK, DIM,
        input  OUT_VALID, RGB, BLINK_PHASE
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, IN_VALID, COLOR, BLINK, DIM,
        output OUT_VALID, RGB, BLINK_PHASE
    );
endinterface

// File: rtl/block_palette_unit_blink_timer.sv
// -----------------------------------------------------------------------------
// block_blink_timer
// Free-running counter 0..BLINK_DIV-1; the blink phase toggles on the same
// edge at which the counter wraps to 0.
//   CLK          pixel clock
//   RST          asynchronous, active-high reset (counter=0, phase=0)
//   BLINK_PHASE  current blink phase (1 = blanked half)
// -----------------------------------------------------------------------------
module block_blink_timer #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic CLK,
    input  logic RST,
    output logic BLINK_PHASE
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            BLINK_PHASE <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt         <= '0;
            BLINK_PHASE <= ~BLINK_PHASE;
        end else begin
            cnt         <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/block_palette_unit.sv
// -----------------------------------------------------------------------------
// block_palette_unit
// Writable RGB palette indexed by block colour code, with a 2-stage lookup
// pipeline applying per-pixel blink and dim effects.
//   CLK   pixel clock
//   RST   asynchronous, active-high reset: clears the pipeline and blink
//         timer and reloads the default palette
//   bus   slave side of block_palette_unit_if (write port, lookup request,
//         RGB result, blink phase)
// Indices >= PAL_DEPTH (lookup or write) alias to entry PAL_DEPTH-1.
// -----------------------------------------------------------------------------
module block_palette_unit
    import block_palette_unit_pkg::*;
#(
    parameter int COLOR_W   = 3,
    parameter int RGB_W     = 12,
    parameter int PAL_DEPTH = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              CLK,
    input  logic              RST,
    block_palette_unit_if.slave bus
);

    localparam int IDX_W = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
    localparam int CH_W  = RGB_W / 3;

    logic [RGB_W-1:0] pal [PAL_DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [RGB_W-1:0] rd_entry;
    logic             blink_phase;

    logic             vld_p1;
    logic             blink_p1;
    logic             dim_p1;
    logic [RGB_W-1:0] entry_p1;

    logic             vld_p2;
    logic [RGB_W-1:0] rgb_p2;

    function automatic logic [IDX_W-1:0] map_idx(input logic [COLOR_W-1:0] idx);
        if (32'(idx) >= 32'(PAL_DEPTH))
            return IDX_W'(PAL_DEPTH - 1);
        else
            return IDX_W'(idx);
    endfunction

    // Halve every channel on its own: shift the whole word, then clear each
    // channel MSB so no bit leaks in from the neighbouring channel.
    function automatic logic [RGB_W-1:0] dim_half(input logic [RGB_W-1:0] e);
        logic [RGB_W-1:0] keep;
        keep = '1;
        for (int c = 0; c < 3; c++)
            keep[c*CH_W + CH_W - 1] = 1'b0;
        return (e >> 1) & keep;
    endfunction

    function automatic logic [RGB_W-1:0] apply_effect(
        input logic [RGB_W-1:0] e,
        input logic             blink,
        input logic             dim,
        input logic             phase
    );
        if (blink && phase)
            return '0;
        else if (dim)
            return dim_half(e);
        else
            return e;
    endfunction

    assign wr_idx = map_idx(bus.WR_ADDR);
    assign rd_idx = map_idx(bus.COLOR);

    // Same-cycle write to the entry being read forwards the new value.
    assign rd_entry = (bus.WR_EN && (wr_idx == rd_idx)) ? bus.WR_DATA : pal[rd_idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < PAL_DEPTH; i++)
                pal[i] <= RGB_W'(default_rgb(i));
        end else if (bus.WR_EN) begin
            pal[wr_idx] <= bus.WR_DATA;
        end
    end

    block_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .CLK         (CLK),
        .RST         (RST),
        .BLINK_PHASE (blink_phase)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1   <= 1'b0;
            blink_p1 <= 1'b0;
            dim_p1   <= 1'b0;
            entry_p1 <= '0;
            vld_p2   <= 1'b0;
            rgb_p2   <= '0;
        end else begin
            // Stage 1: request flags and palette read
            vld_p1   <= bus.IN_VALID;
            blink_p1 <= bus.BLINK;
            dim_p1   <= bus.DIM;
            entry_p1 <= rd_entry;
            // Stage 2: effects with the phase registered before this edge
            vld_p2   <= vld_p1;
            if (vld_p1)
                rgb_p2 <= apply_effect(entry_p1, blink_p1, dim_p1, blink_phase);
        end
    end

    assign bus.OUT_VALID   = vld_p2;
    assign bus.RGB         = rgb_p2;
    assign bus.BLINK_PHASE = blink_phase;

endmodule
